alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq.sv | 122 ++++++++++++
 tb/tb_alu_seq.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared ALU definitions: operand/function-code widths and the function-code map.
// Used by both the combinational alu and the alu_seq request sequencer.
package alu_seq_pkg;

    localparam int REG_DATA_WIDTH_DEF    = 16;
    localparam int ALU_CONTROL_WIDTH_DEF = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_MUL = 4'b0001,
        OP_DIV = 4'b0010,
        OP_ROR = 4'b1000,
        OP_ROL = 4'b1001,
        OP_SLL = 4'b1010,
        OP_SLR = 4'b1011,
        OP_OR  = 4'b1100,
        OP_AND = 4'b1101,
        OP_SUB = 4'b1110,
        OP_ADD = 4'b1111
    } alu_op_e;

    // Codes wider than the defined map are never valid.
    function automatic logic op_is_valid(input int unsigned op);
        logic ok;
        ok = 1'b0;
        if (op < 16) begin
            case (op[3:0])
                OP_NOP, OP_MUL, OP_DIV, OP_ROR, OP_ROL, OP_SLL,
                OP_SLR, OP_OR, OP_AND, OP_SUB, OP_ADD: ok = 1'b1;
                default:                               ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Sequencer around a combinational ALU: IDLE accepts, EXEC drives the ALU one cycle, RESP presents.
// Latency: accept at edge N, result valid for the edge N+2 handshake; backpressure holds RESP, no buffering.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int REG_DATA_WIDTH    = REG_DATA_WIDTH_DEF,
    parameter int ALU_CONTROL_WIDTH = ALU_CONTROL_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ALU_CONTROL_WIDTH-1:0] in_op,
    input  logic [REG_DATA_WIDTH-1:0]    in_a,
    input  logic [REG_DATA_WIDTH-1:0]    in_b,
    output logic [REG_DATA_WIDTH-1:0]    alu_a,
    output logic [REG_DATA_WIDTH-1:0]    alu_b,
    output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
    input  logic [REG_DATA_WIDTH-1:0]    alu_r,
    input  logic [REG_DATA_WIDTH-1:0]    alu_s,
    input  logic                         alu_exc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REG_DATA_WIDTH-1:0]    result_lo,
    output logic [REG_DATA_WIDTH-1:0]    result_hi,
    output logic                         result_exc,
    output logic                         exc_sticky,
    input  logic                         exc_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                       state;
    state_e                       state_nxt;
    logic [ALU_CONTROL_WIDTH-1:0] op_q;
    logic [REG_DATA_WIDTH-1:0]    a_q;
    logic [REG_DATA_WIDTH-1:0]    b_q;
    logic                         op_valid;
    logic                         cap_exc;

    assign op_valid = op_is_valid(32'(op_q));
    // An unknown function code is reported as an exception without consulting the ALU.
    assign cap_exc  = op_valid ? alu_exc : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_a       = a_q;
                alu_b       = b_q;
                alu_control = op_valid ? op_q : '0;
                state_nxt   = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (state == IDLE && in_valid) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo  <= '0;
            result_hi  <= '0;
            result_exc <= 1'b0;
        end else if (state == EXEC) begin
            result_lo  <= op_valid ? alu_r : '0;
            result_hi  <= op_valid ? alu_s : '0;
            result_exc <= cap_exc;
        end
    end

    // A capture of a new exception outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_sticky <= 1'b0;
        end else if (state == EXEC && cap_exc) begin
            exc_sticky <= 1'b1;
        end else if (exc_clr) begin
            exc_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU and a queue of expected results.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_control;
    logic [15:0] alu_r;
    logic [15:0] alu_s;
    logic        alu_exc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic        result_exc;
    logic        exc_sticky;
    logic        exc_clr;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        exc;
    } res_t;

    res_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   accepts;
    int   stray;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_r       (alu_r),
        .alu_s       (alu_s),
        .alu_exc     (alu_exc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .result_exc  (result_exc),
        .exc_sticky  (exc_sticky),
        .exc_clr     (exc_clr)
    );

    // Behavioural ALU; NOP passes alu_a through so a leaked NOP result is visible.
    always_comb begin
        logic [31:0] prod;
        prod    = 32'(alu_a) * 32'(alu_b);
        alu_r   = alu_a;
        alu_s   = '0;
        alu_exc = 1'b0;
        case (alu_control)
            OP_ADD: begin
                alu_r   = alu_a + alu_b;
                alu_exc = (alu_a[15] == alu_b[15]) && (alu_r[15] != alu_a[15]);
            end
            OP_SUB: begin
                alu_r   = alu_a - alu_b;
                alu_exc = (alu_a[15] != alu_b[15]) && (alu_r[15] != alu_a[15]);
            end
            OP_AND: alu_r = alu_a & alu_b;
            OP_OR:  alu_r = alu_a | alu_b;
            OP_MUL: {alu_s, alu_r} = prod;
            OP_DIV: begin
                if (alu_b == 16'h0) begin
                    alu_r   = '0;
                    alu_exc = 1'b1;
                end else begin
                    alu_r = alu_a / alu_b;
                    alu_s = alu_a % alu_b;
                end
            end
            OP_SLL: alu_r = alu_a << alu_b[3:0];
            OP_SLR: alu_r = alu_a >> alu_b[3:0];
            OP_ROL: alu_r = (alu_a << alu_b[3:0]) | (alu_a >> (5'd16 - {1'b0, alu_b[3:0]}));
            OP_ROR: alu_r = (alu_a >> alu_b[3:0]) | (alu_a << (5'd16 - {1'b0, alu_b[3:0]}));
            default: alu_r = alu_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_res(input logic [15:0] lo, input logic [15:0] hi, input logic exc);
        res_t e;
        e.lo  = lo;
        e.hi  = hi;
        e.exc = exc;
        sb_q.push_back(e);
    endtask

    // Entered and left at a falling edge; returns during the EXEC cycle.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   n;
        res_t e;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sb"}, 32'(sb_q.size() > 0), 32'd1);
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        check({tag, "_lo"}, 32'(result_lo), 32'(e.lo));
        check({tag, "_hi"}, 32'(result_hi), 32'(e.hi));
        check({tag, "_exc"}, 32'(result_exc), 32'(e.exc));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        exc_clr   = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", {result_hi, result_lo}, 32'd0);
        check("rst_exc", {30'd0, result_exc, exc_sticky}, 32'd0);
        check("rst_alu", {alu_control, alu_a[11:0], alu_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with latency and EXEC-only ALU drive
        expect_res(16'h0007, 16'h0000, 1'b0);
        send(OP_ADD, 16'h0003, 16'h0004);
        check("exec_alu_a", 32'(alu_a), 32'h0003);
        check("exec_alu_b", 32'(alu_b), 32'h0004);
        check("exec_alu_ctl", 32'(alu_control), 32'hF);
        check("exec_out_valid", 32'(out_valid), 32'd0);
        check("exec_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        collect("add");
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_alu_zero", {alu_control, alu_a[11:0], alu_b}, 32'd0);
        check("idle_retain_lo", 32'(result_lo), 32'h0007);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        expect_res(16'h3400, 16'h0012, 1'b0);
        send(OP_MUL, 16'h1234, 16'h0100);
        collect("mul");
        @(negedge clk);

        // Overflow, sticky set, clear, then clear coincident with a new exception
        expect_res(16'h8000, 16'h0000, 1'b1);
        send(OP_ADD, 16'h7FFF, 16'h0001);
        collect("ovf");
        check("sticky_set", 32'(exc_sticky), 32'd1);
        @(negedge clk);
        exc_clr = 1'b1;
        @(negedge clk);
        exc_clr = 1'b0;
        check("sticky_clr", 32'(exc_sticky), 32'd0);
        exc_clr = 1'b1;
        expect_res(16'h8000, 16'h0000, 1'b1);
        send(OP_ADD, 16'h7FFF, 16'h0001);
        @(negedge clk);
        check("sticky_set_wins", 32'(exc_sticky), 32'd1);
        exc_clr = 1'b0;
        collect("ovf2");
        @(negedge clk);

        // Backpressure in RESP with ignored request pulses
        out_ready = 1'b0;
        expect_res(16'h000D, 16'h0000, 1'b0);
        send(OP_SUB, 16'h0010, 16'h0003);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = OP_ADD;
            in_a     = 16'h1111;
            in_b     = 16'h2222;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold", {result_hi, result_lo}, 32'h0000_000D);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        collect("bp");
        @(negedge clk);
        check("bp_release", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_no_extra", 32'(out_valid), 32'd0);

        expect_res(16'h0000, 16'h0000, 1'b1);
        send(4'b0101, 16'h1234, 16'h5678);
        check("inv_alu_ctl", 32'(alu_control), 32'h0);
        collect("inv");
        @(negedge clk);

        expect_res(16'h000E, 16'h0002, 1'b0);
        send(OP_DIV, 16'h0064, 16'h0007);
        collect("div");
        @(negedge clk);

        expect_res(16'h0018, 16'h0000, 1'b0);
        send(OP_ROL, 16'h8001, 16'h0004);
        collect("rol");
        @(negedge clk);

        // Back-to-back with in_valid held high: two accepts in six cycles
        accepts  = 0;
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 16'h0001;
        in_b     = 16'h0002;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) collect("tput");
            if (in_ready) begin
                expect_res(16'h0003, 16'h0000, 1'b0);
                accepts++;
            end
            if (i == 5) in_valid = 1'b0;
            @(negedge clk);
        end
        check("tput_accepts", 32'(accepts), 32'd2);

        // Reset in the middle of EXEC
        send(OP_ADD, 16'h0005, 16'h0005);
        rst_n = 1'b0;
        #1;
        check("arst_alu", {alu_control, alu_a[11:0], alu_b}, 32'd0);
        check("arst_result", {result_hi, result_lo}, 32'd0);
        check("arst_flags", {29'd0, result_exc, exc_sticky, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        check("arst_no_resp", 32'(stray), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
